// File: rtl/bitty_fetch_sequencer.sv
// Program sequencer for the Bitty core: fetches 16-bit words, issues run, waits for done.
// Optional EXEC watchdog compiled in with `define BITTY_FETCH_WATCHDOG_EN.
module bitty_fetch_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int LAST_ADDR   = 2**ADDR_W-1,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       retired
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;
  logic              stop_pend_q, stop_pend_d;
  logic              busy_st;

  assign busy_st = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                   (state_q == S_ISSUE) || (state_q == S_EXEC);

`ifdef BITTY_FETCH_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdog_expire;

  // Counter is zeroed while issuing so it starts at 0 on EXEC entry.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_ISSUE) begin
      wdog_d = '0;
    end else if ((state_q == S_EXEC) && !done) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign wdog_expire = (state_q == S_EXEC) && !done && (wdog_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic wdog_expire;
  logic unused_wdog_cfg;
  assign wdog_expire     = 1'b0;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    stop_pend_d = stop_pend_q;
    if (busy_st && stop) begin
      stop_pend_d = 1'b1;
    end
    case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          state_d     = S_FETCH;
          pc_d        = '0;
          retired_d   = '0;
          stop_pend_d = 1'b0;
        end
      end
      S_FETCH: state_d = stop_pend_q ? S_HALT : S_LOAD;
      S_LOAD: begin
        instr_d = mem_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        // done wins over a watchdog expiry in the same cycle.
        if (done) begin
          retired_d = sat_inc16(retired_q);
          if ((pc_q == LAST_PC) || stop_pend_q || stop) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (wdog_expire) begin
          state_d = S_FAULT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      retired_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign retired     = retired_q;
  assign run         = (state_q == S_ISSUE);
  assign busy        = busy_st;
  assign halted      = (state_q == S_HALT);
`ifdef BITTY_FETCH_WATCHDOG_EN
  assign fault       = (state_q == S_FAULT);
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// Scoreboard bench for bitty_fetch_sequencer: expected (pc, instruction) pairs per run pulse.
module tb_bitty_fetch_sequencer;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset, start, stop, done, run, busy, halted, fault;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_data, instruction, retired;

  logic [15:0] mem [0:255];
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          core_lat = 2;
  int          cnt = 0;
  logic        force_done = 1'b0;

  bitty_fetch_sequencer #(.ADDR_W(ADDR_W), .LAST_ADDR(5), .WDOG_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .mem_addr(mem_addr), .mem_data(mem_data), .instruction(instruction),
    .run(run), .done(done), .pc(pc), .busy(busy), .halted(halted),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
    mem[3] = 16'hDEF0; mem[4] = 16'h0F0F; mem[5] = 16'hA5A5;
  end

  always @(posedge clk) mem_data <= mem[mem_addr];

  // Core model: done arrives core_lat cycles after run (never if core_lat==0).
  always @(posedge clk) begin
    if (reset) cnt <= 0;
    else if (run && core_lat > 0) cnt <= core_lat;
    else if (cnt > 0) cnt <= cnt - 1;
  end
  assign done = (cnt == 1) || force_done;

  function automatic logic [15:0] exp_word(input int a);
    case (a)
      0: return 16'h1234;
      1: return 16'h5678;
      2: return 16'h9ABC;
      3: return 16'hDEF0;
      4: return 16'h0F0F;
      5: return 16'hA5A5;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back({8'(a), exp_word(a)});
  endtask

  // Monitor: every run pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (run) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL run_unexpected pc=%h instr=%h required=no run", pc, instruction);
      end else begin
        e = exp_q.pop_front();
        if ({pc, instruction} !== e) begin
          failures++;
          $display("FAIL run_word pc/instr=%h/%h required=%h/%h", pc, instruction, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_halt actual=timeout required=halted"); end
  endtask

  task automatic wait_run_pc(input logic [7:0] p, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (run && pc == p) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_run actual=timeout required=run at pc %0h", p); end
  endtask

  task automatic wait_pc(input logic [7:0] p, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pc == p) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_pc actual=timeout required=pc %0h", p); end
  endtask

  task automatic stop_now();
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_run"}, run, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_instr"}, instruction, 0);
    check({tag, "_retired"}, retired, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Full program to LAST_ADDR with done two cycles after run.
    push_range(0, 5);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("c1_busy", busy, 1);
    check("c1_addr", mem_addr, 0);
    check("c1_run", run, 0);
    @(negedge clk);
    check("c2_run", run, 0);
    @(negedge clk);
    check("c3_run", run, 1);
    check("c3_instr", instruction, 16'h1234);
    wait_halt(200);
    check("s1_retired", retired, 6);
    check("s1_pc", pc, 5);
    check("s1_busy", busy, 0);
    check("s1_queue", exp_q.size(), 0);

    // stop during ISSUE of pc=3: instruction 3 completes, no further run.
    push_range(0, 3);
    pulse_start();
    wait_run_pc(8'd3, 100);
    stop_now();
    wait_halt(50);
    check("s3_pc", pc, 3);
    check("s3_retired", retired, 4);
    repeat (10) @(negedge clk);
    check("s3_still_halted", halted, 1);

    // Halt with retired=5 for the restart test.
    push_range(0, 4);
    pulse_start();
    wait_run_pc(8'd4, 100);
    stop_now();
    wait_halt(50);
    check("s6a_retired", retired, 5);

    // Restart from HALT with spurious done during FETCH and LOAD.
    push_range(0, 5);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; force_done = 1'b1;
    @(negedge clk);
    check("s6_retired_clr", retired, 0);
    check("s6_pc", pc, 0);
    check("s6_halted", halted, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 force_done = 1'b0;
    @(negedge clk);
    check("s6_run_c3", run, 1);
    check("s2_no_count", retired, 0);
    wait_pc(8'd1, 20);
    check("s2_retired_once", retired, 1);

    // reset during EXEC at pc=5.
    wait_run_pc(8'd5, 100);
    @(negedge clk);
    check("s4_exec_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("s4");
    push_range(0, 0);
    pulse_start();
    @(negedge clk);
    check("s4_fetch_addr", mem_addr, 0);
    check("s4_fetch_busy", busy, 1);
    wait_run_pc(8'd0, 10);
    stop_now();
    wait_halt(50);
    check("s4_pc", pc, 0);
    check("s4_retired", retired, 1);

`ifdef BITTY_FETCH_WATCHDOG_EN
    // Core never answers: FAULT after 8 EXEC cycles, then restart.
    core_lat = 0;
    push_range(0, 0);
    pulse_start();
    wait_run_pc(8'd0, 10);
    repeat (8) @(negedge clk);
    check("s5_pre_fault", fault, 0);
    check("s5_pre_busy", busy, 1);
    @(negedge clk);
    check("s5_fault", fault, 1);
    check("s5_busy", busy, 0);
    check("s5_pc", pc, 0);
    check("s5_retired", retired, 0);
    core_lat = 2;
    push_range(0, 0);
    pulse_start();
    @(negedge clk);
    check("s5_restart_fault", fault, 0);
    check("s5_restart_pc", pc, 0);
    wait_run_pc(8'd0, 10);
    stop_now();
    wait_halt(50);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
